// File: rtl/fifo_read_ctrl.sv
// Read-side controller for the 8-entry register-file FIFO: read pointer, pop/error decision,
// registered read data with one-cycle ack. Optional macro FIFO_RD_ERR_STICKY_EN makes rd_err sticky.
module fifo_read_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    re_i,
    input  logic [3:0]              wr_ptr_i,
    input  logic [8*DATA_WIDTH-1:0] reg_data_i,
    output logic [3:0]              rd_ptr_o,
    output logic [DATA_WIDTH-1:0]   dout_o,
    output logic                    rd_ack_o,
    output logic                    rd_err_o,
    output logic                    empty_o,
    output logic [3:0]              data_count_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic [DATA_WIDTH-1:0]   rd_entry;

    // Wrap bit only distinguishes full from empty; the entry is picked by the low 3 bits.
    assign empty_o      = (wr_ptr_i == rd_ptr_q);
    assign data_count_o = wr_ptr_i - rd_ptr_q;

    always_comb begin
        rd_entry = '0;
        for (int i = 0; i < 8; i++) begin
            if (rd_ptr_q[2:0] == i[2:0]) rd_entry = reg_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_d  = IDLE;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        if (re_i) begin
            if (!empty_o) begin
                state_d  = POP;
                rd_ptr_d = rd_ptr_q + 4'd1;
                dout_d   = rd_entry;
            end else begin
                state_d  = ERR;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
        end
    end

    assign rd_ptr_o = rd_ptr_q;
    assign dout_o   = dout_q;
    assign rd_ack_o = (state_q == POP);

`ifdef FIFO_RD_ERR_STICKY_EN
    // Held from the first error until a successful pop clears it.
    logic err_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else if (state_d == ERR) begin
            err_q <= 1'b1;
        end else if (state_d == POP) begin
            err_q <= 1'b0;
        end
    end

    assign rd_err_o = err_q;
`else
    assign rd_err_o = (state_q == ERR);
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Scoreboard bench for fifo_read_ctrl: directed per-cycle vectors push hand-computed
// expected outputs; a negedge monitor pops and compares.
module tb_fifo_read_ctrl;

    localparam int W = 32;
`ifdef FIFO_RD_ERR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           re;
    logic [3:0]     wr_ptr;
    logic [8*W-1:0] reg_data;
    logic [3:0]     rd_ptr;
    logic [W-1:0]   dout;
    logic           rd_ack, rd_err, empty;
    logic [3:0]     data_count;
    logic [W-1:0]   mem [8];

    typedef struct {
        logic [3:0]   ptr;
        logic [W-1:0] dout;
        logic         ack;
        logic         err;
        logic         empty;
        logic [3:0]   cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    always_comb begin
        reg_data = '0;
        for (int i = 0; i < 8; i++) reg_data[i*W +: W] = mem[i];
    end

    fifo_read_ctrl #(.DATA_WIDTH(W)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .re_i         (re),
        .wr_ptr_i     (wr_ptr),
        .reg_data_i   (reg_data),
        .rd_ptr_o     (rd_ptr),
        .dout_o       (dout),
        .rd_ack_o     (rd_ack),
        .rd_err_o     (rd_err),
        .empty_o      (empty),
        .data_count_o (data_count)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, expv);
        end
    endtask

    // Monitor: the DUT presents a fresh output set every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rd_ptr",     {28'd0, rd_ptr},     {28'd0, e.ptr});
                check("dout",       dout,                e.dout);
                check("rd_ack",     {31'd0, rd_ack},     {31'd0, e.ack});
                check("rd_err",     {31'd0, rd_err},     {31'd0, e.err});
                check("empty",      {31'd0, empty},      {31'd0, e.empty});
                check("data_count", {28'd0, data_count}, {28'd0, e.cnt});
            end
        end
    end

    // Apply this cycle's inputs and push the outputs expected during this cycle.
    task automatic vec(input logic rst, input logic r, input logic [3:0] wp,
                       input logic [3:0] eptr, input logic [W-1:0] edout, input logic eack,
                       input logic eerr_pulse, input logic eerr_sticky,
                       input logic eempty, input logic [3:0] ecnt);
        exp_t e;
        #1;
        reset  = rst;
        re     = r;
        wr_ptr = wp;
        e.ptr = eptr; e.dout = edout; e.ack = eack;
        e.err = STICKY ? eerr_sticky : eerr_pulse;
        e.empty = eempty; e.cnt = ecnt;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    initial begin
        reset = 1'b1; re = 1'b0; wr_ptr = 4'd0;
        for (int i = 0; i < 8; i++) mem[i] = 32'hA0 + i;
        mem[7] = 32'h77;
        @(posedge clk);
        //   rst re  wr      ptr    dout     ack ep es emp cnt
        vec(0, 0, 4'd0,  4'd0, 32'h0,  0, 0, 0, 1, 4'd0);   // reset state
        vec(0, 1, 4'd3,  4'd0, 32'h0,  0, 0, 0, 0, 4'd3);
        vec(0, 1, 4'd3,  4'd1, 32'hA0, 1, 0, 0, 0, 4'd2);
        vec(0, 1, 4'd3,  4'd2, 32'hA1, 1, 0, 0, 0, 4'd1);
        vec(0, 0, 4'd3,  4'd3, 32'hA2, 1, 0, 0, 1, 4'd0);
        vec(0, 1, 4'd5,  4'd3, 32'hA2, 0, 0, 0, 0, 4'd2);
        vec(0, 1, 4'd5,  4'd4, 32'hA3, 1, 0, 0, 0, 4'd1);
        vec(0, 1, 4'd5,  4'd5, 32'hA4, 1, 0, 0, 1, 4'd0);   // read while empty
        vec(0, 0, 4'd5,  4'd5, 32'hA4, 0, 1, 1, 1, 4'd0);
        vec(0, 0, 4'd5,  4'd5, 32'hA4, 0, 0, 1, 1, 4'd0);
        mem[0] = 32'h88;
        vec(0, 1, 4'd7,  4'd5, 32'hA4, 0, 0, 1, 0, 4'd2);
        vec(0, 1, 4'd7,  4'd6, 32'hA5, 1, 0, 0, 0, 4'd1);
        vec(0, 1, 4'd9,  4'd7, 32'hA6, 1, 0, 0, 0, 4'd2);   // pointer 7 -> 8 wrap
        vec(0, 1, 4'd9,  4'd8, 32'h77, 1, 0, 0, 0, 4'd1);
        vec(0, 1, 4'd9,  4'd9, 32'h88, 1, 0, 0, 1, 4'd0);   // re held after last pop
        vec(0, 0, 4'd9,  4'd9, 32'h88, 0, 1, 1, 1, 4'd0);
        mem[1] = 32'hB1;
        vec(0, 1, 4'd11, 4'd9, 32'h88, 0, 0, 1, 0, 4'd2);
        vec(1, 1, 4'd11, 4'd10, 32'hB1, 1, 0, 0, 0, 4'd1);  // reset beats re
        for (int i = 0; i < 8; i++) mem[i] = 32'hC0 + i;
        vec(0, 0, 4'd8,  4'd0, 32'h0,  0, 0, 0, 0, 4'd8);   // full lap: 8 entries
        vec(0, 1, 4'd8,  4'd0, 32'h0,  0, 0, 0, 0, 4'd8);
        for (int k = 1; k < 8; k++)
            vec(0, 1, 4'd8, 4'(k), 32'hC0 + k - 1, 1, 0, 0, 0, 4'(8 - k));
        vec(0, 1, 4'd8,  4'd8, 32'hC7, 1, 0, 0, 1, 4'd0);   // ninth read errors
        vec(0, 0, 4'd8,  4'd8, 32'hC7, 0, 1, 1, 1, 4'd0);
        vec(0, 0, 4'd8,  4'd8, 32'hC7, 0, 0, 1, 1, 4'd0);
        vec(0, 0, 4'd1,  4'd8, 32'hC7, 0, 0, 1, 0, 4'd9);   // write-side overrun visible only
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
